// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the hazard controller's pipeline-facing signals.
//   master : pipeline side (drives ID/EX/memory status, receives enables/flushes)
//   slave  : hazard_ctrl itself
// Inputs : ID_rs1/ID_rs2/ID_use_rs1/ID_use_rs2, EX_rd/EX_MemRead/EX_muldiv/
//          EX_branch_taken, IM_stall/DM_stall
// Outputs: PC_write, IF_ID_write/flush, ID_EX_write/flush, EX_MEM_write/flush,
//          md_busy, hz_state
interface hazard_ctrl_if;
  logic [4:0] ID_rs1;
  logic [4:0] ID_rs2;
  logic       ID_use_rs1;
  logic       ID_use_rs2;
  logic [4:0] EX_rd;
  logic       EX_MemRead;
  logic       EX_muldiv;
  logic       EX_branch_taken;
  logic       IM_stall;
  logic       DM_stall;
  logic       PC_write;
  logic       IF_ID_write;
  logic       IF_ID_flush;
  logic       ID_EX_write;
  logic       ID_EX_flush;
  logic       EX_MEM_write;
  logic       EX_MEM_flush;
  logic       md_busy;
  logic [1:0] hz_state;

  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_MemRead,
           EX_muldiv, EX_branch_taken, IM_stall, DM_stall,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
           EX_MEM_write, EX_MEM_flush, md_busy, hz_state
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_MemRead,
           EX_muldiv, EX_branch_taken, IM_stall, DM_stall,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
           EX_MEM_write, EX_MEM_flush, md_busy, hz_state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the six-stage pipeline. Handles the
// hazards forwarding cannot cover: load-use, multi-cycle mul/div in EX,
// taken-branch redirect and instruction/data memory wait.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   hz   : hazard_ctrl_if.slave (pipeline status in, enables/flushes out)
// Optional feature macro HAZARD_PERF_EN adds:
//   perf_stall_cycles[31:0] : cycles with PC_write=0 (saturating)
//   perf_flushes[31:0]      : cycles with any flush asserted (saturating)
// Outputs are combinational from the registered state/counter and inputs;
// while rst is low they are forced to their idle values.
module hazard_ctrl #(
  parameter int LOAD_USE_STALL = 2,
  parameter int MD_LATENCY     = 4,
  parameter int CNT_W          = 4
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]  perf_stall_cycles,
  output logic [31:0]  perf_flushes
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MD_BUSY  = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  state_t           r_state, w_state_n;
  state_t           r_ret,   w_ret_n;
  logic [CNT_W-1:0] r_cnt,   w_cnt_n;
  logic             r_md_done, w_md_done_n;

  logic w_mem, w_lu;

  assign w_mem = hz.IM_stall | hz.DM_stall;
  assign w_lu  = hz.EX_MemRead && (hz.EX_rd != 5'd0) &&
                 ((hz.ID_use_rs1 && (hz.ID_rs1 == hz.EX_rd)) ||
                  (hz.ID_use_rs2 && (hz.ID_rs2 == hz.EX_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_ret     <= RUN;
      r_cnt     <= '0;
      r_md_done <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_ret     <= w_ret_n;
      r_cnt     <= w_cnt_n;
      r_md_done <= w_md_done_n;
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_ret_n         = r_ret;
    w_cnt_n         = r_cnt;
    w_md_done_n     = r_md_done;
    hz.PC_write     = 1'b1;
    hz.IF_ID_write  = 1'b1;
    hz.IF_ID_flush  = 1'b0;
    hz.ID_EX_write  = 1'b1;
    hz.ID_EX_flush  = 1'b0;
    hz.EX_MEM_write = 1'b1;
    hz.EX_MEM_flush = 1'b0;
    hz.md_busy      = 1'b0;
    hz.hz_state     = r_state;

    if (!rst) begin
      // outputs stay at idle values while reset is held
      hz.hz_state = RUN;
    end else begin
      case (r_state)
        RUN: begin
          // a completed mul/div only blocks re-entry for one RUN cycle
          w_md_done_n = 1'b0;
          if (w_mem) begin
            hz.PC_write = 1'b0; hz.IF_ID_write = 1'b0;
            hz.ID_EX_write = 1'b0; hz.EX_MEM_write = 1'b0;
            w_ret_n   = RUN;
            w_state_n = MEM_WAIT;
          end else if (hz.EX_branch_taken) begin
            hz.IF_ID_flush = 1'b1;
            hz.ID_EX_flush = 1'b1;
          end else if (hz.EX_muldiv && !r_md_done && (MD_LATENCY > 1)) begin
            hz.PC_write = 1'b0; hz.IF_ID_write = 1'b0; hz.ID_EX_write = 1'b0;
            hz.EX_MEM_flush = 1'b1;
            hz.md_busy      = 1'b1;
            w_cnt_n = CNT_W'(MD_LATENCY - 2);
            if (MD_LATENCY > 2) w_state_n   = MD_BUSY;
            else                w_md_done_n = 1'b1;
          end else if (w_lu) begin
            hz.PC_write = 1'b0; hz.IF_ID_write = 1'b0;
            hz.ID_EX_flush = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              w_cnt_n   = CNT_W'(LOAD_USE_STALL - 1);
              w_state_n = LU_STALL;
            end
          end
        end

        LU_STALL: begin
          if (w_mem) begin
            hz.PC_write = 1'b0; hz.IF_ID_write = 1'b0;
            hz.ID_EX_write = 1'b0; hz.EX_MEM_write = 1'b0;
            w_ret_n   = LU_STALL;
            w_state_n = MEM_WAIT;
          end else begin
            hz.PC_write = 1'b0; hz.IF_ID_write = 1'b0;
            hz.ID_EX_flush = 1'b1;
            if (r_cnt <= CNT_W'(1)) w_state_n = RUN;
            else                    w_cnt_n   = r_cnt - CNT_W'(1);
          end
        end

        MD_BUSY: begin
          if (w_mem) begin
            hz.PC_write = 1'b0; hz.IF_ID_write = 1'b0;
            hz.ID_EX_write = 1'b0; hz.EX_MEM_write = 1'b0;
            w_ret_n   = MD_BUSY;
            w_state_n = MEM_WAIT;
          end else begin
            hz.PC_write = 1'b0; hz.IF_ID_write = 1'b0; hz.ID_EX_write = 1'b0;
            hz.EX_MEM_flush = 1'b1;
            hz.md_busy      = 1'b1;
            if (r_cnt <= CNT_W'(1)) begin
              w_state_n   = RUN;
              w_md_done_n = 1'b1;
            end else begin
              w_cnt_n = r_cnt - CNT_W'(1);
            end
          end
        end

        default: begin // MEM_WAIT: frozen, including the release cycle
          hz.PC_write = 1'b0; hz.IF_ID_write = 1'b0;
          hz.ID_EX_write = 1'b0; hz.EX_MEM_write = 1'b0;
          if (!w_mem) w_state_n = r_ret;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (!hz.PC_write && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if ((hz.IF_ID_flush || hz.ID_EX_flush || hz.EX_MEM_flush) &&
          (perf_flushes != 32'hFFFF_FFFF))
        perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/flush controller for the six-stage pipeline.
- Covers the hazards that operand forwarding cannot resolve:
  - load-use dependencies;
  - multi-cycle mul/div occupancy in EX;
  - taken-branch redirect;
  - instruction/data memory wait.
- Drives write-enable and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Runs alongside the forward unit.

Parameters:
- LOAD_USE_STALL, 2, bubbles inserted per load-use hazard (1..7).
- MD_LATENCY, 4, total EX-occupancy cycles of a mul/div (1..15).
- CNT_W, 4, stall counter width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-low
- ID_rs1  input  5  ID source reg 1
- ID_rs2  input  5  ID source reg 2
- ID_use_rs1  input  1  ID instruction reads rs1
- ID_use_rs2  input  1  ID instruction reads rs2
- EX_rd  input  5  EX destination reg
- EX_MemRead  input  1  EX instruction is a load
- EX_muldiv  input  1  EX instruction is mul/div
- EX_branch_taken  input  1  EX resolved taken branch/jump
- IM_stall  input  1  instruction memory not ready
- DM_stall  input  1  data memory not ready
- PC_write  output  1  PC update enable
- IF_ID_write  output  1  IF/ID register enable
- IF_ID_flush  output  1  IF/ID becomes NOP
- ID_EX_write  output  1  ID/EX register enable
- ID_EX_flush  output  1  ID/EX becomes bubble
- EX_MEM_write  output  1  EX/MEM register enable
- EX_MEM_flush  output  1  EX/MEM becomes bubble
- md_busy  output  1  mul/div occupying EX
- hz_state  output  2  current state (0 RUN, 1 LU_STALL, 2 MD_BUSY, 3 MEM_WAIT)

Behaviour:
- Outputs are combinational from registered state/counter plus inputs.
  - Default values: all *_write=1, all *_flush=0, md_busy=0.
- Reset (rst=0, async): state=RUN, cnt=0, ret_state=RUN, md_done=0; outputs at default values.
- "Freeze" means PC_write=IF_ID_write=ID_EX_write=EX_MEM_write=0 and no flushes.
- RUN priority, highest first:
  1. IM_stall|DM_stall: freeze; ret_state<=RUN; next MEM_WAIT.
  2. EX_branch_taken: IF_ID_flush=1, ID_EX_flush=1; stay RUN. Suppresses load-use detection that cycle.
  3. EX_muldiv & !md_done & MD_LATENCY>1: PC_write=IF_ID_write=ID_EX_write=0, EX_MEM_flush=1, md_busy=1.
     - cnt<=MD_LATENCY-2.
     - Next state: MD_BUSY if MD_LATENCY>2, else RUN with md_done<=1.
  4. Load-use, i.e. EX_MemRead & EX_rd!=0 & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)): PC_write=IF_ID_write=0, ID_EX_flush=1.
     - Next state: LU_STALL with cnt<=LOAD_USE_STALL-1 if LOAD_USE_STALL>1, else RUN.
  5. Otherwise: default outputs.
- md_done is cleared on any RUN cycle where it was set. This prevents re-triggering on the same mul/div.
- LU_STALL:
  - Outputs as in load-use.
  - EX_* inputs are ignored (EX holds a bubble).
  - cnt==1 -> RUN; else cnt--.
  - Total bubbles = LOAD_USE_STALL.
- MD_BUSY:
  - Outputs as in mul/div entry.
  - cnt==1 -> RUN with md_done<=1; else cnt--.
  - The mul/div advances to MEM exactly MD_LATENCY cycles after entering EX.
- Memory stall in LU_STALL/MD_BUSY:
  - Freeze (overrides flushes).
  - ret_state<=current state; cnt holds; next MEM_WAIT.
- MEM_WAIT:
  - Freeze while IM_stall|DM_stall.
  - When both are low, freeze still applies that cycle; next state=ret_state.
  - Counter resumes where it paused.
- Boundaries:
  - EX_rd=0 never triggers load-use.
  - Branch and load-use simultaneous: branch wins.
  - Mul/div and load are mutually exclusive in EX.
  - Counter never underflows: cnt is only decremented when >1.
- Reset mid-operation returns to RUN in the same cycle (async); any pending stall is discarded.

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_flushes[31:0].
  - perf_stall_cycles increments every cycle PC_write=0.
  - perf_flushes increments every cycle IF_ID_flush|ID_EX_flush|EX_MEM_flush.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Load x5 in EX, ID add uses rs1=x5, defaults -> PC_write=0 and ID_EX_flush=1 for exactly 2 cycles (hz_state 1 on 2nd), then RUN, PC_write=1.
- EX_muldiv=1 held, MD_LATENCY=4 -> PC_write=0, EX_MEM_flush=1, md_busy=1 for 3 cycles; 4th cycle all writes 1, md_busy=0; no retrigger.
- EX_branch_taken=1 with load-use condition also true -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1, state stays RUN.
- DM_stall=1 for 3 cycles during MD_BUSY (cnt=1) -> full freeze, hz_state=3; after release, 1 more MD_BUSY cycle then RUN.
- Load with EX_rd=0, ID_rs1=0 -> no stall, default outputs.
- rst low during LU_STALL -> immediately hz_state=0, PC_write=1; after release no residual bubble.
